pipe_alu_core: RTL and testbench
================================

# pipe_alu_core

Parametrised four-stage register/ALU/memory pipeline. This is the next generation of the team's `pipe_ex` datapath: one clock, asynchronous reset, configurable data, register and memory widths. It adds a valid/ready issue handshake, a hold (stall) input, bubble tracking, operand and load forwarding, an explicit store enable, a load operation and status flags. It sits between the instruction sequencer and the result bus, and owns its register bank and data memory.

## Interface
- `WIDTH`, 16: data width of registers, ALU and memory words.
- `RA`, 4: register-address width; the bank has 2^RA entries.
- `AW`, 8: memory-address width; memory has 2^AW words.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  an instruction is presented this cycle.
- `in_ready`  out  1  equals `!hold`; an instruction issues on a rising edge with `in_valid && in_ready`.
- `hold`  in  1  freezes every stage register, the register bank and memory.
- `rs1`, `rs2`, `rd`  in  RA  source and destination registers.
- `func`  in  4  operation code.
- `st`  in  1  store the result to `mem[addr]` in stage 4.
- `addr`  in  AW  memory address, used for both store and load.
- `zout`  out  WIDTH  stage-3 result (the `L34_Z` register).
- `zout_valid`  out  1  `zout` belongs to a real instruction.
- `flags`  out  4  {err, C, N, Z} of the `zout` instruction.

## Operation
- Reset clears all stage registers, valid bits, `zout`, `zout_valid`, `flags` and every register-bank entry to 0. Memory is not reset.
- **S1 (issue)** captures `regbank[rs1]`/`regbank[rs2]` into A/B, plus rs1, rs2, rd, func, st, addr and v1. If no instruction issues, v1 = 0 (a bubble).
- **S2 (execute)** computes Z from the forwarded operands and captures rd, st, addr, flags and v2 = v1.
- **S3 (writeback)**: if v2, writes `regbank[rd] <= Z`. Always captures `L34_Z`, addr, st, flags and v3 = v2.
- **S4 (store)**: if v3 && st, writes `mem[addr] <= L34_Z`.
- **Operand forwarding in S2**, per operand: use the S3 Z if v2 and `L23_rd == rs`. Otherwise use `L34_Z` if v3 and `L34_rd == rs`. Otherwise use the S1 value. S3 has priority over S4. Consequence: back-to-back dependent instructions need no stalls.
- **Func codes**:
  - 0 A+B; 1 A−B; 2 A*B (low WIDTH bits); 3 A; 4 B; 5 A&B; 6 A|B; 7 A^B; 8 −A; 9 −B; 10 A>>1 (logical); 11 B<<1.
  - 12 load: `mem[addr]`, with forwarding — S3 Z if v2 && L23 st && address match, else `L34_Z` if v3 && L34 st && address match, else memory.
  - 13–15: Z = 0, err = 1.
- **Flags**:
  - Z: result is 0.
  - N: result MSB.
  - C: carry out of the add; for sub, borrow (A < B unsigned); for mul, OR of the high WIDTH product bits; for 11, the shifted-out bit B[WIDTH-1]; 0 otherwise.
  - All arithmetic is unsigned, modulo 2^WIDTH.
- Bubbles carry no writes. `zout` still updates, with `zout_valid` = 0 and flags = 0.

## Timing
- An instruction issued at edge E is executed at E+1. At E+2 it writes the register bank and updates `zout`/`zout_valid`/`flags`. Memory is written at E+3.
- Latency from issue to `zout` is 2 cycles after the issue edge; throughput is 1 per cycle.
- **`hold` high**: no register, bank or memory write occurs, outputs are stable and `in_ready` = 0. Forwarding state is preserved, so resuming is seamless.
- **Same-edge register read/write**: a read in S1 on the same edge as an S3 write returns the old value; forwarding from S4 covers this case.
- **Reset mid-operation**: all in-flight instructions are discarded and no pending store completes.

## Test plan
- **Reset**: `rst_n` = 0 → `zout` = 0, `zout_valid` = 0, `flags` = 0, every register reads 0. Release, then issue func 3 rs1=5 → `zout` = 0 with Z = 1.
- **Dependency chain**: preload r1 = 3 and r2 = 4. Issue back-to-back r3=r1+r2, r4=r3+r3, r5=r4−r1 → `zout` = 7, 14, 11 on consecutive cycles, all valid.
- **Arithmetic edges**: with WIDTH = 16, 0xFFFF+1 → 0 with Z = 1, C = 1. 0−1 → 0xFFFF with N = 1, C = 1. 0x0100*0x0100 → 0 with C = 1. func 14 → 0 with err = 1.
- **Store then load**: issue st to addr 0x20 with Z = 0xABCD, then a func 12 load at addr 0x20 on the next cycle → 0xABCD forwarded. Repeat with two bubbles between them → 0xABCD read from memory.
- **Hold**: assert `hold` for 3 cycles mid-chain → outputs frozen and `in_ready` = 0. After release, results match the no-hold run exactly, with no duplicate or lost writes.
- **Bubbles and reset abort**: with `in_valid` = 0 gaps, `zout_valid` goes low and no register changes. Assert `rst_n` low while a store is in S3 → the memory word is unchanged.

Source files
------------

// File: rtl/pipe_alu_core.sv
// rtl/pipe_alu_core.sv - four-stage register/ALU/memory pipeline with forwarding
// S1 issue/read, S2 execute, S3 register writeback, S4 memory store.
module pipe_alu_core #(
  parameter int WIDTH = 16,
  parameter int RA    = 4,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  input  logic [RA-1:0]    rs1,
  input  logic [RA-1:0]    rs2,
  input  logic [RA-1:0]    rd,
  input  logic [3:0]       func,
  input  logic             st,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] zout,
  output logic             zout_valid,
  output logic [3:0]       flags
);
  localparam int NREG = 1 << RA;
  localparam int NMEM = 1 << AW;

  logic [WIDTH-1:0] regbank_q [NREG];
  logic [WIDTH-1:0] mem_q     [NMEM];

  logic [WIDTH-1:0] a_q, b_q;
  logic [RA-1:0]    rs1_q, rs2_q, rd1_q;
  logic [3:0]       func_q;
  logic             st1_q, v1_q;
  logic [AW-1:0]    addr1_q;

  logic [WIDTH-1:0] z2_q;
  logic [RA-1:0]    rd2_q;
  logic             st2_q, v2_q;
  logic [AW-1:0]    addr2_q;
  logic [3:0]       flags2_q;

  logic [WIDTH-1:0] z3_q;
  logic [RA-1:0]    rd3_q;
  logic             st3_q, v3_q;
  logic [AW-1:0]    addr3_q;
  logic [3:0]       flags3_q;

  logic [WIDTH-1:0]   opa, opb, ld_data, z_d;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic               carry, err;
  logic [3:0]         flags_d;

  assign in_ready   = !hold;
  assign zout       = z3_q;
  assign zout_valid = v3_q;
  assign flags      = flags3_q;

  // S3 result takes priority over S4 for both register and memory forwarding
  always_comb begin
    opa = a_q;
    if (v2_q && rd2_q == rs1_q)      opa = z2_q;
    else if (v3_q && rd3_q == rs1_q) opa = z3_q;
    opb = b_q;
    if (v2_q && rd2_q == rs2_q)      opb = z2_q;
    else if (v3_q && rd3_q == rs2_q) opb = z3_q;
    ld_data = mem_q[addr1_q];
    if (v2_q && st2_q && addr2_q == addr1_q)      ld_data = z2_q;
    else if (v3_q && st3_q && addr3_q == addr1_q) ld_data = z3_q;
  end

  always_comb begin
    sum   = {1'b0, opa} + {1'b0, opb};
    diff  = {1'b0, opa} - {1'b0, opb};
    prod  = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
    z_d   = '0;
    carry = 1'b0;
    err   = 1'b0;
    case (func_q)
      4'd0:  begin z_d = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      4'd1:  begin z_d = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      4'd2:  begin z_d = prod[WIDTH-1:0]; carry = |prod[2*WIDTH-1:WIDTH]; end
      4'd3:  z_d = opa;
      4'd4:  z_d = opb;
      4'd5:  z_d = opa & opb;
      4'd6:  z_d = opa | opb;
      4'd7:  z_d = opa ^ opb;
      4'd8:  z_d = -opa;
      4'd9:  z_d = -opb;
      4'd10: z_d = opa >> 1;
      4'd11: begin z_d = opb << 1; carry = opb[WIDTH-1]; end
      4'd12: z_d = ld_data;
      default: err = 1'b1;
    endcase
    flags_d = v1_q ? {err, carry, z_d[WIDTH-1], (z_d == '0)} : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd1_q    <= '0;
      func_q   <= '0;
      st1_q    <= 1'b0;
      addr1_q  <= '0;
      v1_q     <= 1'b0;
      z2_q     <= '0;
      rd2_q    <= '0;
      st2_q    <= 1'b0;
      addr2_q  <= '0;
      flags2_q <= '0;
      v2_q     <= 1'b0;
      z3_q     <= '0;
      rd3_q    <= '0;
      st3_q    <= 1'b0;
      addr3_q  <= '0;
      flags3_q <= '0;
      v3_q     <= 1'b0;
    end else if (!hold) begin
      a_q      <= regbank_q[rs1];
      b_q      <= regbank_q[rs2];
      rs1_q    <= rs1;
      rs2_q    <= rs2;
      rd1_q    <= rd;
      func_q   <= func;
      st1_q    <= st;
      addr1_q  <= addr;
      v1_q     <= in_valid;
      z2_q     <= z_d;
      rd2_q    <= rd1_q;
      st2_q    <= st1_q;
      addr2_q  <= addr1_q;
      flags2_q <= flags_d;
      v2_q     <= v1_q;
      z3_q     <= z2_q;
      rd3_q    <= rd2_q;
      st3_q    <= st2_q;
      addr3_q  <= addr2_q;
      flags3_q <= flags2_q;
      v3_q     <= v2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regbank_q[i] <= '0;
    end else if (!hold && v2_q) begin
      regbank_q[rd2_q] <= z2_q;
    end
  end

  // Memory is deliberately not reset; v3_q clears asynchronously so a pending store dies
  always_ff @(posedge clk) begin
    if (!hold && v3_q && st3_q) mem_q[addr3_q] <= z3_q;
  end
endmodule

// File: tb/tb_pipe_alu_core.sv
// tb/tb_pipe_alu_core.sv - scoreboard bench for pipe_alu_core
module tb_pipe_alu_core;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, hold, st, zout_valid;
  logic [3:0]  rs1, rs2, rd, func, flags;
  logic [7:0]  addr;
  logic [15:0] zout;

  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] exp_q[$];

  logic        last_valid = 1'b0;
  logic [15:0] last_z = '0;
  logic [3:0]  last_flags = '0;

  always #5 clk = ~clk;

  pipe_alu_core #(.WIDTH(16), .RA(4), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .st(st), .addr(addr),
    .zout(zout), .zout_valid(zout_valid), .flags(flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rdd,
                       input logic [3:0] f, input logic s, input logic [7:0] a,
                       input logic [15:0] ez, input logic [3:0] ef);
    @(negedge clk);
    in_valid = 1'b1; hold = 1'b0;
    rs1 = r1; rs2 = r2; rd = rdd; func = f; st = s; addr = a;
    exp_q.push_back({ez, ef});
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; hold = 1'b0;
    end
  endtask

  // Bubbles carrying an aggressive payload that must not write anything
  task automatic junk_bubble(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; hold = 1'b0;
      rs1 = 4'd8; rs2 = 4'd8; rd = 4'd1; func = 4'd11; st = 1'b1; addr = 8'h30;
    end
  endtask

  task automatic hold_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      hold = 1'b1; in_valid = 1'b1;
      rs1 = 4'd1; rs2 = 4'd1; rd = 4'd2; func = 4'd0; st = 1'b0; addr = 8'h00;
      #1 check("in_ready_hold", in_ready, 1'b0);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_zout", zout, 16'h0);
    check("rst_zout_valid", zout_valid, 1'b0);
    check("rst_flags", flags, 4'h0);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected result per non-held edge that presents a valid output
  initial begin
    logic rst_s, hold_s;
    logic [19:0] e;
    forever begin
      @(posedge clk);
      rst_s = rst_n; hold_s = hold;
      #1;
      if (!rst_s || !rst_n) begin
        last_valid = 1'b0; last_z = '0; last_flags = '0;
      end else if (hold_s) begin
        check("hold_zout_valid", zout_valid, last_valid);
        check("hold_flags", flags, last_flags);
        if (last_valid) check("hold_zout", zout, last_z);
      end else if (zout_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_result: got zout %0h with empty queue", zout);
        end else begin
          e = exp_q.pop_front();
          check("zout", zout, e[19:4]);
          check("flags", flags, e[3:0]);
          last_valid = 1'b1; last_z = e[19:4]; last_flags = e[3:0];
        end
      end else begin
        check("bubble_flags", flags, 4'h0);
        last_valid = 1'b0; last_flags = 4'h0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; func = '0; st = 1'b0; addr = '0;
    dut.mem_q[8'h01] <= 16'd3;
    dut.mem_q[8'h02] <= 16'd4;
    dut.mem_q[8'h03] <= 16'hFFFF;
    dut.mem_q[8'h04] <= 16'h0001;
    dut.mem_q[8'h05] <= 16'h0100;
    dut.mem_q[8'h06] <= 16'hABCD;
    dut.mem_q[8'h20] <= 16'h0000;
    dut.mem_q[8'h21] <= 16'h0000;
    dut.mem_q[8'h22] <= 16'h0000;
    dut.mem_q[8'h30] <= 16'h1111;
    dut.mem_q[8'h31] <= 16'h2222;
    repeat (2) @(negedge clk);
    check("init_zout", zout, 16'h0);
    check("init_zout_valid", zout_valid, 1'b0);
    check("init_flags", flags, 4'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) issue(r[3:0], 4'd0, 4'd0, 4'd3, 1'b0, 8'h00, 16'h0000, 4'b0001);

    issue(4'd0, 4'd0, 4'd1, 4'd12, 1'b0, 8'h01, 16'd3, 4'b0000);
    issue(4'd0, 4'd0, 4'd2, 4'd12, 1'b0, 8'h02, 16'd4, 4'b0000);
    issue(4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 8'h00, 16'd7, 4'b0000);
    issue(4'd3, 4'd3, 4'd4, 4'd0, 1'b0, 8'h00, 16'd14, 4'b0000);
    issue(4'd4, 4'd1, 4'd5, 4'd1, 1'b0, 8'h00, 16'd11, 4'b0000);

    issue(4'd0, 4'd0, 4'd8,  4'd12, 1'b0, 8'h03, 16'hFFFF, 4'b0010);
    issue(4'd0, 4'd0, 4'd9,  4'd12, 1'b0, 8'h04, 16'h0001, 4'b0000);
    issue(4'd0, 4'd0, 4'd10, 4'd12, 1'b0, 8'h05, 16'h0100, 4'b0000);
    issue(4'd8,  4'd9,  4'd15, 4'd0,  1'b0, 8'h00, 16'h0000, 4'b0101);
    issue(4'd0,  4'd9,  4'd15, 4'd1,  1'b0, 8'h00, 16'hFFFF, 4'b0110);
    issue(4'd10, 4'd10, 4'd15, 4'd2,  1'b0, 8'h00, 16'h0000, 4'b0101);
    issue(4'd8,  4'd9,  4'd15, 4'd14, 1'b0, 8'h00, 16'h0000, 4'b1001);
    issue(4'd0,  4'd8,  4'd15, 4'd11, 1'b0, 8'h00, 16'hFFFE, 4'b0110);
    issue(4'd8,  4'd0,  4'd15, 4'd10, 1'b0, 8'h00, 16'h7FFF, 4'b0000);
    issue(4'd9,  4'd0,  4'd15, 4'd8,  1'b0, 8'h00, 16'hFFFF, 4'b0010);
    issue(4'd8,  4'd10, 4'd15, 4'd7,  1'b0, 8'h00, 16'hFEFF, 4'b0010);
    issue(4'd8,  4'd10, 4'd15, 4'd5,  1'b0, 8'h00, 16'h0100, 4'b0000);
    issue(4'd9,  4'd10, 4'd15, 4'd6,  1'b0, 8'h00, 16'h0101, 4'b0000);
    issue(4'd0,  4'd9,  4'd15, 4'd4,  1'b0, 8'h00, 16'h0001, 4'b0000);
    issue(4'd0,  4'd10, 4'd15, 4'd9,  1'b0, 8'h00, 16'hFF00, 4'b0010);
    issue(4'd9,  4'd0,  4'd15, 4'd1,  1'b0, 8'h00, 16'h0001, 4'b0000);
    issue(4'd10, 4'd10, 4'd15, 4'd0,  1'b0, 8'h00, 16'h0200, 4'b0000);

    issue(4'd0, 4'd0, 4'd6, 4'd12, 1'b0, 8'h06, 16'hABCD, 4'b0010);
    issue(4'd6, 4'd0, 4'd7, 4'd3,  1'b1, 8'h20, 16'hABCD, 4'b0010);
    issue(4'd0, 4'd0, 4'd8, 4'd12, 1'b0, 8'h20, 16'hABCD, 4'b0010);
    issue(4'd6, 4'd0, 4'd7, 4'd3,  1'b1, 8'h22, 16'hABCD, 4'b0010);
    bubble(1);
    issue(4'd0, 4'd0, 4'd8, 4'd12, 1'b0, 8'h22, 16'hABCD, 4'b0010);
    issue(4'd6, 4'd0, 4'd7, 4'd3,  1'b1, 8'h21, 16'hABCD, 4'b0010);
    bubble(2);
    issue(4'd0, 4'd0, 4'd8, 4'd12, 1'b0, 8'h21, 16'hABCD, 4'b0010);

    issue(4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 8'h00, 16'd7, 4'b0000);
    issue(4'd3, 4'd3, 4'd4, 4'd0, 1'b0, 8'h00, 16'd14, 4'b0000);
    hold_cycles(3);
    issue(4'd4, 4'd1, 4'd5, 4'd1, 1'b0, 8'h00, 16'd11, 4'b0000);

    junk_bubble(3);
    issue(4'd1, 4'd0, 4'd15, 4'd3, 1'b0, 8'h00, 16'd3, 4'b0000);
    issue(4'd2, 4'd0, 4'd15, 4'd3, 1'b0, 8'h00, 16'd4, 4'b0000);
    issue(4'd3, 4'd0, 4'd15, 4'd3, 1'b0, 8'h00, 16'd7, 4'b0000);
    issue(4'd5, 4'd0, 4'd15, 4'd3, 1'b0, 8'h00, 16'd11, 4'b0000);

    issue(4'd0, 4'd0, 4'd6, 4'd12, 1'b0, 8'h31, 16'h2222, 4'b0000);
    issue(4'd6, 4'd0, 4'd7, 4'd3,  1'b1, 8'h30, 16'h2222, 4'b0000);
    bubble(1);
    reset_pulse();
    issue(4'd0, 4'd0, 4'd1, 4'd12, 1'b0, 8'h30, 16'h1111, 4'b0000);
    issue(4'd6, 4'd0, 4'd15, 4'd3, 1'b0, 8'h00, 16'h0000, 4'b0001);
    bubble(5);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
